// File: rtl/if_stage_bp.sv
// if_stage_bp: MIPS instruction-fetch stage with a direct-mapped 2-bit BTB predictor,
// IF/ID pipeline register, ID jump redirects and EX branch-resolution corrections.
module if_stage_bp #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int BTB_IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        id_redirect,
    input  logic [31:0] id_target,
    input  logic        ex_br_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_pred_taken,
    output logic [31:0] ifid_pred_target,
    output logic        mispredict
);
    localparam int N  = 1 << BTB_IDX_W;
    localparam int TW = 30 - BTB_IDX_W;

    logic [31:0]          pc, pc_plus4, pc_next, correct_pc, pred_target;
    logic                 btb_valid  [N];
    logic [TW-1:0]        btb_tag    [N];
    logic [31:0]          btb_target [N];
    logic [1:0]           btb_ctr    [N];
    logic [BTB_IDX_W-1:0] idx, ex_idx;
    logic                 hit, ex_hit, pred_taken, flush;
    logic [1:0]           ctr_upd;

    assign imem_addr   = pc;
    assign pc_plus4    = pc + 32'd4;
    assign idx         = pc[BTB_IDX_W+1:2];
    assign ex_idx      = ex_pc[BTB_IDX_W+1:2];
    assign hit         = btb_valid[idx] && btb_tag[idx] == pc[31:BTB_IDX_W+2];
    assign ex_hit      = btb_valid[ex_idx] && btb_tag[ex_idx] == ex_pc[31:BTB_IDX_W+2];
    assign pred_taken  = hit && btb_ctr[idx][1];
    assign pred_target = btb_target[idx];

    assign mispredict = ex_br_valid && ((ex_taken != ex_pred_taken) ||
                                        (ex_taken && ex_target != ex_pred_target));
    assign correct_pc = ex_taken ? ex_target : ex_pc + 32'd4;
    assign flush      = mispredict || id_redirect;

    always_comb begin
        pc_next = mispredict ? correct_pc : id_redirect ? id_target : stall ? pc :
                  pred_taken ? pred_target : pc_plus4;
        ctr_upd = ex_taken ? (btb_ctr[ex_idx] == 2'b11 ? 2'b11 : btb_ctr[ex_idx] + 2'b01)
                           : (btb_ctr[ex_idx] == 2'b00 ? 2'b00 : btb_ctr[ex_idx] - 2'b01);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc <= RESET_PC;
        else     pc <= pc_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            ifid_valid       <= 1'b0;
            ifid_instr       <= 32'h0;
            ifid_pc          <= 32'h0;
            ifid_pc_plus4    <= 32'h0;
            ifid_pred_taken  <= 1'b0;
            ifid_pred_target <= 32'h0;
        end else if (!stall) begin
            ifid_valid       <= 1'b1;
            ifid_instr       <= imem_data;
            ifid_pc          <= pc;
            ifid_pc_plus4    <= pc_plus4;
            ifid_pred_taken  <= pred_taken;
            ifid_pred_target <= pred_target;
        end
    end

    // Training ignores stall/flush: a resolved branch always updates its entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= 32'h0;
                btb_ctr[i]    <= 2'b01;
            end
        end else if (ex_br_valid) begin
            if (ex_hit) begin
                btb_ctr[ex_idx] <= ctr_upd;
                if (ex_taken) btb_target[ex_idx] <= ex_target;
            end else if (ex_taken) begin
                btb_valid[ex_idx]  <= 1'b1;
                btb_tag[ex_idx]    <= ex_pc[31:BTB_IDX_W+2];
                btb_target[ex_idx] <= ex_target;
                btb_ctr[ex_idx]    <= 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_if_stage_bp.sv
// tb_if_stage_bp: directed vectors for if_stage_bp; stimulus pushes per-cycle
// expectations into a queue, a negedge monitor pops and compares.
module tb_if_stage_bp;
    localparam logic [31:0] K = 32'hC0DE_0000;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] imem_addr, imem_data;
    logic        stall, id_redirect, ex_br_valid, ex_taken, ex_pred_taken;
    logic [31:0] id_target, ex_pc, ex_target, ex_pred_target;
    logic        ifid_valid, ifid_pred_taken, mispredict;
    logic [31:0] ifid_instr, ifid_pc, ifid_pc_plus4, ifid_pred_target;

    typedef struct {
        logic [31:0] addr;
        logic        mis;
        logic        v;
        logic [31:0] ipc;
        logic        pt;
        logic [31:0] ptg;
        logic        z;
    } exp_t;

    exp_t q[$];
    int   vectors = 0, miscompares = 0;

    always #5 clk = ~clk;
    assign imem_data = imem_addr ^ K;

    if_stage_bp dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .stall(stall), .id_redirect(id_redirect), .id_target(id_target),
        .ex_br_valid(ex_br_valid), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .ifid_valid(ifid_valid),
        .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4),
        .ifid_pred_taken(ifid_pred_taken), .ifid_pred_target(ifid_pred_target),
        .mispredict(mispredict)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("imem_addr", imem_addr, e.addr);
            chk("mispredict", {31'b0, mispredict}, {31'b0, e.mis});
            chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, e.v});
            chk("ifid_pred_taken", {31'b0, ifid_pred_taken}, {31'b0, e.pt});
            chk("ifid_instr", ifid_instr, e.v ? e.ipc ^ K : 32'h0);
            if (e.v) begin
                chk("ifid_pc", ifid_pc, e.ipc);
                chk("ifid_pc_plus4", ifid_pc_plus4, e.ipc + 32'd4);
            end
            if (e.pt) chk("ifid_pred_target", ifid_pred_target, e.ptg);
            if (e.z) begin
                chk("rst_ifid_pc", ifid_pc, 32'h0);
                chk("rst_ifid_pc_plus4", ifid_pc_plus4, 32'h0);
                chk("rst_ifid_pred_target", ifid_pred_target, 32'h0);
            end
        end
    end

    task automatic idle();
        stall = 0; id_redirect = 0; id_target = 0; ex_br_valid = 0; ex_pc = 0;
        ex_taken = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
    endtask

    task automatic idr(input logic [31:0] t);
        id_redirect = 1; id_target = t;
    endtask

    task automatic ex(input logic [31:0] p, input logic tk, input logic [31:0] tg,
                      input logic ptk, input logic [31:0] ptg);
        ex_br_valid = 1; ex_pc = p; ex_taken = tk; ex_target = tg;
        ex_pred_taken = ptk; ex_pred_target = ptg;
    endtask

    task automatic expect_now(input logic [31:0] a, input logic m, input logic v,
                              input logic [31:0] ipc, input logic pt, input logic [31:0] ptg,
                              input logic z);
        exp_t e;
        e.addr = a; e.mis = m; e.v = v; e.ipc = ipc; e.pt = pt; e.ptg = ptg; e.z = z;
        q.push_back(e);
    endtask

    // Called at posedge+1 after inputs are set; checks this cycle, then advances.
    task automatic cyc(input logic [31:0] a, input logic m, input logic v,
                       input logic [31:0] ipc, input logic pt, input logic [31:0] ptg);
        expect_now(a, m, v, ipc, pt, ptg, 1'b0);
        @(posedge clk); #1;
        idle();
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        cyc(32'h0,  0, 0, 32'h0, 0, 0);
        cyc(32'h4,  0, 1, 32'h0, 0, 0);
        stall = 1;
        cyc(32'h8,  0, 1, 32'h4, 0, 0);
        stall = 1;
        cyc(32'h8,  0, 1, 32'h4, 0, 0);
        cyc(32'h8,  0, 1, 32'h4, 0, 0);
        cyc(32'hC,  0, 1, 32'h8, 0, 0);
        ex(32'h10, 1, 32'h40, 0, 32'h0);
        cyc(32'h10, 1, 1, 32'hC, 0, 0);
        cyc(32'h40, 0, 0, 32'h0, 0, 0);
        idr(32'h10);
        cyc(32'h44, 0, 1, 32'h40, 0, 0);
        cyc(32'h10, 0, 0, 32'h0, 0, 0);
        cyc(32'h40, 0, 1, 32'h10, 1, 32'h40);
        ex(32'h10, 1, 32'h40, 1, 32'h40);
        cyc(32'h44, 0, 1, 32'h40, 0, 0);
        ex(32'h10, 1, 32'h40, 1, 32'h40);
        cyc(32'h48, 0, 1, 32'h44, 0, 0);
        ex(32'h10, 1, 32'h40, 1, 32'h40);
        cyc(32'h4C, 0, 1, 32'h48, 0, 0);
        ex(32'h10, 0, 32'h0, 0, 32'h0);
        cyc(32'h50, 0, 1, 32'h4C, 0, 0);
        idr(32'h10);
        cyc(32'h54, 0, 1, 32'h50, 0, 0);
        cyc(32'h10, 0, 0, 32'h0, 0, 0);
        ex(32'h10, 0, 32'h0, 0, 32'h0); idr(32'h10);
        cyc(32'h40, 0, 1, 32'h10, 1, 32'h40);
        cyc(32'h10, 0, 0, 32'h0, 0, 0);
        cyc(32'h14, 0, 1, 32'h10, 0, 0);
        stall = 1; idr(32'h200); ex(32'hFC, 1, 32'h100, 0, 32'h0);
        cyc(32'h18, 1, 1, 32'h14, 0, 0);
        cyc(32'h100, 0, 0, 32'h0, 0, 0);
        ex(32'hFFFF_FFFC, 0, 32'h0, 1, 32'h1234);
        cyc(32'h104, 1, 1, 32'h100, 0, 0);
        ex(32'h20, 1, 32'h80, 1, 32'h84);
        cyc(32'h0,  1, 0, 32'h0, 0, 0);
        cyc(32'h80, 0, 0, 32'h0, 0, 0);
        cyc(32'h84, 0, 1, 32'h80, 0, 0);
        // Reset lands mid-cycle with a jump pending; the monitor samples before any edge.
        idr(32'h20);
        expect_now(32'h0, 0, 0, 32'h0, 0, 0, 1'b1);
        #2 rst = 1;
        @(posedge clk); #1;
        rst = 0; idle();
        idr(32'h20);
        cyc(32'h0,  0, 0, 32'h0, 0, 0);
        cyc(32'h20, 0, 0, 32'h0, 0, 0);
        cyc(32'h24, 0, 1, 32'h20, 0, 0);
        @(negedge clk); #1;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
